instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/isa_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch front end: instruction width, the
// halt encoding, datapath field positions and the fetch sequencer states.
package isa_pkg;

  localparam int INSTR_W = 20;

  // Instruction word that ends a program
  localparam logic [INSTR_W-1:0] HALT_WORD = 20'hFFFFF;

  // Field positions inside an instruction word
  localparam int RS1_MSB      = 19;
  localparam int RS1_LSB      = 15;
  localparam int RS2_MSB      = 14;
  localparam int RS2_LSB      = 10;
  localparam int REG_WE_BIT   = 9;
  localparam int ALU_OP_MSB   = 8;
  localparam int ALU_OP_LSB   = 6;
  localparam int RAM_ADDR_MSB = 5;
  localparam int RAM_ADDR_LSB = 1;
  localparam int RAM_WE_BIT   = 0;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer. Each entry carries the instruction word and
// the address it was fetched from. Flush empties the buffer in one cycle and
// wins over a push or pop in the same cycle.
module fetch_fifo import isa_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_data,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [INSTR_W-1:0] head_data,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [1:0]         count
);

  logic [INSTR_W-1:0] data_mem [2];
  logic [ADDR_W-1:0]  pc_mem   [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic               do_push;
  logic               do_pop;

  // A pop from an empty buffer is ignored; a push into a full buffer is only
  // accepted when the head leaves in the same cycle.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  assign head_data = data_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Streams words from a synchronous instruction
// memory (data one cycle after the read enable) into a two-entry buffer whose
// head is presented to the datapath with a valid/ready handshake. Supports
// redirects, wrap-around addressing and stopping on the halt word.
module instr_fetch #(
  parameter int                             ADDR_W    = 8,
  parameter logic [isa_pkg::INSTR_W-1:0]    HALT_WORD = isa_pkg::HALT_WORD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          imem_en,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [isa_pkg::INSTR_W-1:0]   imem_data,
  output logic [isa_pkg::INSTR_W-1:0]   instr,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  input  logic                          jump_en,
  input  logic [ADDR_W-1:0]             jump_addr,
  output logic [ADDR_W-1:0]             pc,
  output logic                          busy,
  output logic                          halted
);

  import isa_pkg::*;

  fetch_state_t       state;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               resp_valid;
  logic [ADDR_W-1:0]  resp_pc;

  logic               active;
  logic               resp_is_halt;
  logic               push;
  logic               pop;
  logic               flush;
  logic [2:0]         slots_used;
  logic [INSTR_W-1:0] head_data;
  logic [ADDR_W-1:0]  head_pc;
  logic [1:0]         fifo_count;

  assign active       = (state == FETCH) || (state == DRAIN);
  assign resp_is_halt = resp_valid && (imem_data == HALT_WORD);

  assign instr_valid = active && (fifo_count != 2'd0);
  assign pop         = instr_valid && instr_ready;

  // The halt word is never buffered, and nothing arriving during a redirect
  // is kept.
  assign push  = (state == FETCH) && resp_valid && !resp_is_halt && !jump_en;
  assign flush = active && jump_en;

  // Buffer slots that are spoken for once this cycle settles: stored words
  // plus the word arriving now, minus the word leaving now. The read issued
  // this cycle returns next cycle, so it only fits if a slot remains free.
  // Counting the same-cycle pop keeps one word per cycle flowing.
  assign slots_used = {1'b0, fifo_count} + {2'b00, resp_valid} - {2'b00, pop};

  assign imem_en   = (state == FETCH) && !rst && !jump_en && !resp_is_halt &&
                     (slots_used < 3'd2);
  assign imem_addr = fetch_addr;

  assign instr  = instr_valid ? head_data : '0;
  assign pc     = instr_valid ? head_pc   : '0;
  assign busy   = active;
  assign halted = (state == HALTED);

  // Sequencer: state, next fetch address and the in-flight read tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_addr <= '0;
      resp_valid <= 1'b0;
      resp_pc    <= '0;
    end else begin
      resp_valid <= imem_en;
      if (imem_en) begin
        resp_pc    <= fetch_addr;
        fetch_addr <= fetch_addr + 1'b1;
      end

      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state      <= FETCH;
            fetch_addr <= '0;
          end
        end
        FETCH: begin
          if (jump_en) begin
            fetch_addr <= jump_addr;
            resp_valid <= 1'b0;
          end else if (resp_is_halt) begin
            state      <= DRAIN;
            resp_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (jump_en) begin
            state      <= FETCH;
            fetch_addr <= jump_addr;
            resp_valid <= 1'b0;
          end else if (fifo_count == 2'd0) begin
            state <= HALTED;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (imem_data),
    .push_pc   (resp_pc),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_data),
    .head_pc   (head_pc),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector tables for streaming,
// back-pressure, reset, redirect and halt, plus a narrow-address instance
// for address wrap-around.
module tb_instr_fetch;
  import isa_pkg::*;

  typedef struct {
    logic        rst;
    logic        start;
    logic        ready;
    logic        jmp;
    logic [7:0]  jaddr;
    logic        en;
    logic [7:0]  addr;
    logic        valid;
    logic [19:0] instr;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        full;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, 8-bit addresses
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [19:0] imem_data = '0;
  logic [19:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;

  // Narrow instance, 4-bit addresses
  logic        start4 = 1'b0;
  logic        imem_en4;
  logic [3:0]  imem_addr4;
  logic [19:0] imem_data4 = '0;
  logic [19:0] instr4;
  logic        instr_valid4;
  logic        jump4 = 1'b0;
  logic [3:0]  jaddr4 = '0;
  logic [3:0]  pc4;
  logic        busy4;
  logic        halted4;

  logic [19:0] mem  [0:255];
  logic [19:0] mem4 [0:15];

  int num_vectors = 0;
  int num_miscompares = 0;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  instr_fetch #(.ADDR_W(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .imem_en     (imem_en4),
    .imem_addr   (imem_addr4),
    .imem_data   (imem_data4),
    .instr       (instr4),
    .instr_valid (instr_valid4),
    .instr_ready (1'b1),
    .jump_en     (jump4),
    .jump_addr   (jaddr4),
    .pc          (pc4),
    .busy        (busy4),
    .halted      (halted4)
  );

  // Synchronous instruction memories: data one cycle after the enable
  always @(posedge clk) begin
    if (imem_en)  imem_data  <= mem[imem_addr];
    if (imem_en4) imem_data4 <= mem4[imem_addr4];
  end

  function automatic logic [19:0] word(input int a);
    logic [7:0] lo;
    lo = a[7:0];
    return {12'hA00, lo};
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic j,
                              input int ja, input logic en, input int ad,
                              input logic vl, input int wi,
                              input logic bz, input logic hl, input logic fl);
    vec_t v;
    v.rst    = r;
    v.start  = s;
    v.ready  = rd;
    v.jmp    = j;
    v.jaddr  = ja[7:0];
    v.en     = en;
    v.addr   = ad[7:0];
    v.valid  = vl;
    v.instr  = vl ? word(wi) : 20'h0;
    v.pc     = vl ? wi[7:0] : 8'h0;
    v.busy   = bz;
    v.halted = hl;
    v.full   = fl;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst         = v.rst;
    start       = v.start;
    instr_ready = v.ready;
    jump_en     = v.jmp;
    jump_addr   = v.jaddr;
    #2;
  endtask

  task automatic checkOutput(input vec_t v, input string tag, input int idx);
    logic ok;
    ok = (imem_en === v.en) && (instr_valid === v.valid) &&
         (busy === v.busy) && (halted === v.halted);
    if (v.en || v.full)
      ok = ok && (imem_addr === v.addr);
    if (v.valid || v.full)
      ok = ok && (instr === v.instr) && (pc === v.pc);
    num_vectors++;
    if (!ok) begin
      num_miscompares++;
      $display("[TB] FAIL %s[%0d]: got en=%b addr=%h valid=%b instr=%h pc=%h busy=%b halted=%b; expected en=%b addr=%h valid=%b instr=%h pc=%h busy=%b halted=%b",
               tag, idx, imem_en, imem_addr, instr_valid, instr, pc, busy, halted,
               v.en, v.addr, v.valid, v.instr, v.pc, v.busy, v.halted);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    num_vectors++;
    if (got !== exp) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic runTable(input vec_t tbl[$], input string tag);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], tag, i);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst         = 1'b1;
    start       = 1'b0;
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = '0;
    start4      = 1'b0;
    jump4       = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t stream_tbl[$];
    vec_t halt_tbl[$];
    int   exp_addr4 [8] = '{0, 0, 14, 15, 0, 1, 2, 3};
    int   exp_pc4   [8] = '{0, 0, 0, 0, 14, 15, 0, 1};

    for (int i = 0; i < 256; i++) mem[i] = word(i);
    for (int i = 0; i < 16; i++)  mem4[i] = {16'hB000, 4'(i)};

    // Stream, stall, reset with a full buffer, redirects
    //                        r  s  rd j  ja     en ad     vl wi     bz hl fl
    stream_tbl.push_back(mk(0, 1, 1, 0, 0,     0, 0,     0, 0,     0, 0, 1));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 0,     0, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 1,     0, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 2,     1, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 1, 1, 0, 0,     1, 3,     1, 1,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 4,     1, 2,     1, 0, 0));
    for (int i = 0; i < 5; i++)
      stream_tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0,     1, 3,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 5,     1, 3,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 6,     1, 4,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 7,     1, 5,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 8,     1, 6,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 7,     1, 0, 0));
    stream_tbl.push_back(mk(1, 1, 0, 1, 'h33,  0, 0,     1, 7,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 0, 1, 'h55,  0, 0,     0, 0,     0, 0, 1));
    stream_tbl.push_back(mk(0, 1, 1, 0, 0,     0, 0,     0, 0,     0, 0, 1));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 0,     0, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 1,     0, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 2,     1, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 1,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 0, 1, 'h40,  0, 0,     1, 1,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 'h40,  0, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 'h41,  0, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 'h42,  1, 'h40,  1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 'h43,  1, 'h41,  1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 1, 'h80,  0, 0,     1, 'h42,  1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 'h80,  0, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 'h81,  0, 0,     1, 0, 0));
    stream_tbl.push_back(mk(0, 0, 1, 0, 0,     1, 'h82,  1, 'h80,  1, 0, 0));

    // Halt word at address 3, drained under back-pressure, then restart
    halt_tbl.push_back(mk(0, 1, 1, 0, 0,       0, 0,     0, 0,     0, 0, 1));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       1, 0,     0, 0,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       1, 1,     0, 0,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       1, 2,     1, 0,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       1, 3,     1, 1,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,     1, 2,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,     1, 2,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       0, 0,     1, 2,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       0, 0,     0, 0,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       0, 0,     0, 0,     0, 1, 0));
    halt_tbl.push_back(mk(0, 0, 1, 1, 'h10,    0, 0,     0, 0,     0, 1, 0));
    halt_tbl.push_back(mk(0, 1, 1, 0, 0,       0, 0,     0, 0,     0, 1, 0));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       1, 0,     0, 0,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       1, 1,     0, 0,     1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 1, 0, 0,       1, 2,     1, 0,     1, 0, 0));

    $display("[TB] streaming, stall, reset and redirect vectors");
    doReset();
    runTable(stream_tbl, "stream");

    $display("[TB] halt word vectors");
    mem[3] = HALT_WORD;
    doReset();
    runTable(halt_tbl, "halt");
    doReset();
    mem[3] = word(3);

    $display("[TB] 4-bit address wrap sequence");
    for (int s = 0; s < 8; s++) begin
      logic [3:0]  pc_exp;
      @(negedge clk);
      start4 = (s == 0);
      jump4  = (s == 1);
      jaddr4 = 4'd14;
      #2;
      pc_exp = 4'(exp_pc4[s]);
      checkValue($sformatf("wrap_en[%0d]", s), {31'b0, imem_en4}, {31'b0, (s >= 2)});
      if (s >= 2)
        checkValue($sformatf("wrap_addr[%0d]", s), {28'b0, imem_addr4}, exp_addr4[s]);
      checkValue($sformatf("wrap_valid[%0d]", s), {31'b0, instr_valid4}, {31'b0, (s >= 4)});
      if (s >= 4) begin
        checkValue($sformatf("wrap_pc[%0d]", s), {28'b0, pc4}, {28'b0, pc_exp});
        checkValue($sformatf("wrap_instr[%0d]", s), {12'b0, instr4}, {12'b0, 16'hB000, pc_exp});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
